bmp_write: RTL and testbench
============================

Name: bmp_write

Overview:
- Writes a 24-bit BMP file from a pixel stream to raw SD sectors. It is the write-side counterpart of the sector-level BMP loader.
- On a start pulse it handshakes with the frame-buffer read path and generates the 54-byte BMP header. It then streams pixels as B,G,R bytes with 4-byte row padding.
- Zero-fills the last sector and issues consecutive sector writes from START_SECTOR.
- Sits between the frame-buffer read FIFO and the SD card sector-write controller.

Parameters:
- IMG_WIDTH, 480, image width in pixels (1..4095).
- IMG_HEIGHT, 272, image height in pixels (1..4095).
- START_SECTOR, 32000, first SD sector of the file. Must be a multiple of 8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sd_init_done  in  1  SD card initialisation complete.
- start  in  1  one-cycle pulse that begins a file write.
- ready  out  1  high while in S_IDLE.
- state_code  out  2  status: 0 = SD initialising, 1 = idle, 2 = writing, 3 = last write done.
- read_req  out  1  request to the frame-buffer reader to start a frame.
- read_req_ack  in  1  frame-buffer reader acknowledge.
- pix_rd_en  out  1  pixel FIFO read strobe.
- pix_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}, valid the cycle after pix_rd_en.
- sd_sec_write  out  1  sector write request, level.
- sd_sec_write_addr  out  32  sector address.
- sd_sec_write_data  out  8  byte to write.
- sd_sec_write_data_req  in  1  SD controller requests the next byte.
- sd_sec_write_end  in  1  one-cycle pulse when the current sector write completes.

Behaviour:
- Reset values:
  - ready=1.
  - state_code=0.
  - read_req=0, pix_rd_en=0.
  - sd_sec_write=0, sd_sec_write_addr=START_SECTOR, sd_sec_write_data=0.
  - state=S_IDLE.
- Derived constants (32-bit arithmetic):
  - STRIDE = (IMG_WIDTH*3+3) & ~3.
  - PAD = STRIDE - IMG_WIDTH*3.
  - IMG_SIZE = STRIDE*IMG_HEIGHT.
  - FILE_LEN = 54 + IMG_SIZE.
  - NSEC = ceil(FILE_LEN/512).
- Header, little-endian, byte offsets:
  - 0-1 "BM".
  - 2 FILE_LEN.
  - 6 zero.
  - 10 54.
  - 14 40.
  - 18 width.
  - 22 height.
  - 26 planes 1.
  - 28 bpp 24.
  - 30 compression 0.
  - 34 IMG_SIZE.
  - 38 and 42: 2835.
  - 46 and 50: 0.
- sd_init_done=0: forces S_IDLE and sd_sec_write=0; state_code=0. The write address is kept.
- S_IDLE:
  - state_code=1.
  - start=1 moves to S_REQ.
  - sd_sec_write_addr reloads START_SECTOR.
  - File byte counter fcnt, column/row counters and sector counter clear.
- S_REQ:
  - read_req=1 until read_req_ack=1.
  - Then read_req=0, one prefetch pix_rd_en pulse, go to S_WRITE.
- S_WRITE:
  - state_code=2; sd_sec_write=1.
  - On each sd_sec_write_data_req, sd_sec_write_data is registered with the byte at fcnt, valid the next cycle; fcnt increments.
    - fcnt<54: header byte.
    - Then image bytes: B,G,R of the pixel register, then PAD zero bytes at each row end.
    - fcnt>=FILE_LEN: 0x00.
  - Pixel register: after the R byte is issued, pix_rd_en pulses once to load the next pixel. No read after the last pixel.
  - Guaranteed: sd_sec_write_data_req spacing is at least 3 cycles.
  - On sd_sec_write_end: sd_sec_write=0 for one cycle, sd_sec_write_addr+1, sector counter+1.
    - Counter reaching NSEC goes to S_END.
    - Otherwise sd_sec_write reasserts the next cycle.
- S_END: state_code=3, go to S_IDLE. state_code stays 3 in idle until the next start.
- Ignored inputs:
  - start outside S_IDLE.
  - data_req outside S_WRITE.
  - Extra data_req beyond 512 per sector: returns 0x00 with no counter change past the 512th byte.
- rst_n low mid-file: immediate return to reset values. Partial data on the card is not recovered.

Optional Feature:
- Macro BMP_TOP_DOWN_EN.
- Defined: header height field = -IMG_HEIGHT (two's complement, top-down). Pixels are written in frame-buffer order, first row = top.
- Undefined: height field = +IMG_HEIGHT. The source delivers rows bottom-up; block behaviour is otherwise identical.

Test Plan:
- Defaults, start, SD model capturing bytes:
  - Bytes 0-5 = 42 4D 36 FA 05 00.
  - Offsets 18-21 = E0 01 00 00; 22-25 = 10 01 00 00.
  - 766 sectors written to addresses 32000..32765.
- Same run, last sector: bytes 0-53 are image tail, bytes 54-511 = 0x00, state_code=3 then ready=1.
- IMG_WIDTH=3, IMG_HEIGHT=2, pixels 0x112233, 0x445566, ...:
  - Row bytes 33 22 11 66 55 44 99 88 77 00 00 00.
  - FILE_LEN=78, NSEC=1.
- read_req_ack delayed 50 cycles: read_req held high 50 cycles, no sector write before ack.
- rst_n pulsed low in sector 3: all outputs at reset values the same cycle. A new start rewrites from sector 32000.
- BMP_TOP_DOWN_EN defined, defaults: offsets 22-25 = F0 FE FF FF.

Source files
------------

// File: rtl/bmp_write.sv
// Streams a 24-bit BMP file (54-byte header, B,G,R pixels with 4-byte row padding) into raw SD sectors.
// Optional BMP_TOP_DOWN_EN: header height is written negative (top-down row order).
module bmp_write #(
    parameter int IMG_WIDTH    = 480,
    parameter int IMG_HEIGHT   = 272,
    parameter int START_SECTOR = 32000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        start,
    output logic        ready,
    output logic [1:0]  state_code,
    output logic        read_req,
    input  logic        read_req_ack,
    output logic        pix_rd_en,
    input  logic [23:0] pix_data,
    output logic        sd_sec_write,
    output logic [31:0] sd_sec_write_addr,
    output logic [7:0]  sd_sec_write_data,
    input  logic        sd_sec_write_data_req,
    input  logic        sd_sec_write_end
);

    localparam logic [31:0] ROW_BYTES  = 32'(IMG_WIDTH * 3);
    localparam logic [31:0] STRIDE     = (ROW_BYTES + 32'd3) & ~32'd3;
    localparam logic [31:0] IMG_SIZE   = STRIDE * 32'(IMG_HEIGHT);
    localparam logic [31:0] FILE_LEN   = 32'd54 + IMG_SIZE;
    localparam logic [31:0] NSEC       = (FILE_LEN + 32'd511) >> 9;
    localparam logic [31:0] START_ADDR = 32'(START_SECTOR);
    localparam logic [31:0] LAST_ROW   = 32'(IMG_HEIGHT - 1);
`ifdef BMP_TOP_DOWN_EN
    localparam logic [31:0] HDR_HEIGHT = 32'(-IMG_HEIGHT);
`else
    localparam logic [31:0] HDR_HEIGHT = 32'(IMG_HEIGHT);
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_END} state_t;

    state_t      state, state_nx;
    logic [31:0] fcnt, col, row, sec_cnt;
    logic [1:0]  sub;
    logic [9:0]  sbyte;
    logic        pix_vld_p1;
    logic [23:0] pix_reg;
    logic [7:0]  file_byte;
    logic        last_pix;

    // Little-endian header byte at offset idx; each field is located by its base offset.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [31:0] fld;
        logic [5:0]  base;
        fld  = 32'd0;
        base = 6'd0;
        if (idx < 6'd2)       begin fld = 32'h0000_4D42; base = 6'd0;  end
        else if (idx < 6'd6)  begin fld = FILE_LEN;      base = 6'd2;  end
        else if (idx < 6'd10) begin fld = 32'd0;         base = 6'd6;  end
        else if (idx < 6'd14) begin fld = 32'd54;        base = 6'd10; end
        else if (idx < 6'd18) begin fld = 32'd40;        base = 6'd14; end
        else if (idx < 6'd22) begin fld = 32'(IMG_WIDTH); base = 6'd18; end
        else if (idx < 6'd26) begin fld = HDR_HEIGHT;    base = 6'd22; end
        else if (idx < 6'd28) begin fld = 32'd1;         base = 6'd26; end
        else if (idx < 6'd30) begin fld = 32'd24;        base = 6'd28; end
        else if (idx < 6'd34) begin fld = 32'd0;         base = 6'd30; end
        else if (idx < 6'd38) begin fld = IMG_SIZE;      base = 6'd34; end
        else if (idx < 6'd42) begin fld = 32'd2835;      base = 6'd38; end
        else if (idx < 6'd46) begin fld = 32'd2835;      base = 6'd42; end
        return 8'(fld >> {idx - base, 3'b000});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!sd_init_done) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nx = S_REQ;
                S_REQ:   if (read_req_ack) state_nx = S_WRITE;
                S_WRITE: if (sd_sec_write_end && (sec_cnt + 32'd1 == NSEC)) state_nx = S_END;
                S_END:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready    = (state == S_IDLE);
        read_req = (state == S_REQ);
    end

    // Byte at the current file offset: header, then pixel bytes and row padding, then zero fill.
    always_comb begin
        file_byte = 8'h00;
        if (fcnt < 32'd54) begin
            file_byte = hdr_byte(fcnt[5:0]);
        end else if (fcnt < FILE_LEN && col < ROW_BYTES) begin
            case (sub)
                2'd0:    file_byte = pix_reg[7:0];
                2'd1:    file_byte = pix_reg[15:8];
                default: file_byte = pix_reg[23:16];
            endcase
        end
    end

    assign last_pix = (row == LAST_ROW) && (col == ROW_BYTES - 32'd1);

    // Pixel arrives the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (pix_vld_p1) pix_reg <= pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_code        <= 2'd0;
            pix_rd_en         <= 1'b0;
            pix_vld_p1        <= 1'b0;
            sd_sec_write      <= 1'b0;
            sd_sec_write_addr <= START_ADDR;
            sd_sec_write_data <= 8'h00;
            fcnt              <= 32'd0;
            col               <= 32'd0;
            row               <= 32'd0;
            sub               <= 2'd0;
            sec_cnt           <= 32'd0;
            sbyte             <= 10'd0;
        end else begin
            pix_rd_en  <= 1'b0;
            pix_vld_p1 <= pix_rd_en;
            if (!sd_init_done) begin
                sd_sec_write <= 1'b0;
                state_code   <= 2'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state_code        <= (state_code == 2'd3) ? 2'd3 : 2'd1;
                        sd_sec_write      <= 1'b0;
                        sd_sec_write_addr <= START_ADDR;
                        fcnt              <= 32'd0;
                        col               <= 32'd0;
                        row               <= 32'd0;
                        sub               <= 2'd0;
                        sec_cnt           <= 32'd0;
                        sbyte             <= 10'd0;
                    end
                    S_REQ: begin
                        state_code <= 2'd2;
                        if (read_req_ack) begin
                            pix_rd_en    <= 1'b1;
                            sd_sec_write <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        state_code <= 2'd2;
                        if (sd_sec_write_data_req) begin
                            if (sbyte != 10'd512) begin
                                sd_sec_write_data <= file_byte;
                                fcnt              <= fcnt + 32'd1;
                                sbyte             <= sbyte + 10'd1;
                                if (fcnt >= 32'd54 && fcnt < FILE_LEN) begin
                                    if (col < ROW_BYTES) begin
                                        sub <= (sub == 2'd2) ? 2'd0 : sub + 2'd1;
                                        if (sub == 2'd2 && !last_pix) pix_rd_en <= 1'b1;
                                    end
                                    if (col == STRIDE - 32'd1) begin
                                        col <= 32'd0;
                                        row <= row + 32'd1;
                                    end else begin
                                        col <= col + 32'd1;
                                    end
                                end
                            end else begin
                                sd_sec_write_data <= 8'h00;
                            end
                        end
                        // Drop the write request for one cycle between sectors.
                        if (sd_sec_write_end) begin
                            sd_sec_write      <= 1'b0;
                            sd_sec_write_addr <= sd_sec_write_addr + 32'd1;
                            sec_cnt           <= sec_cnt + 32'd1;
                            sbyte             <= 10'd0;
                            if (sec_cnt + 32'd1 == NSEC) state_code <= 2'd3;
                        end else if (!sd_sec_write) begin
                            sd_sec_write <= 1'b1;
                        end
                    end
                    S_END: begin
                        state_code   <= 2'd3;
                        sd_sec_write <= 1'b0;
                    end
                    default: state_code <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bmp_write.sv
// Bench for bmp_write: SD sector-writer and pixel-FIFO models, file image checked against a byte-level reference.
module tb_bmp_write;

    localparam int W       = 3;
    localparam int H       = 100;
    localparam int SS      = 32000;
    localparam int STRIDE  = (W * 3 + 3) & ~3;
    localparam int PAD     = STRIDE - W * 3;
    localparam int IMGSZ   = STRIDE * H;
    localparam int FLEN    = 54 + IMGSZ;
    localparam int NSEC    = (FLEN + 511) / 512;
    localparam int NBYTES  = NSEC * 512;
    localparam int NPIX    = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sd_init_done;
    logic        start;
    logic        ready;
    logic [1:0]  state_code;
    logic        read_req;
    logic        read_req_ack;
    logic        pix_rd_en;
    logic [23:0] pix_data;
    logic        sd_sec_write;
    logic [31:0] sd_sec_write_addr;
    logic [7:0]  sd_sec_write_data;
    logic        sd_sec_write_data_req;
    logic        sd_sec_write_end;

    bmp_write #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .START_SECTOR(SS)) dut (
        .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done), .start(start),
        .ready(ready), .state_code(state_code), .read_req(read_req),
        .read_req_ack(read_req_ack), .pix_rd_en(pix_rd_en), .pix_data(pix_data),
        .sd_sec_write(sd_sec_write), .sd_sec_write_addr(sd_sec_write_addr),
        .sd_sec_write_data(sd_sec_write_data), .sd_sec_write_data_req(sd_sec_write_data_req),
        .sd_sec_write_end(sd_sec_write_end)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] pix_mem [NPIX];
    logic [7:0]  exp_b   [NBYTES];
    logic [7:0]  cap     [NBYTES];
    int          addr_log[$];
    int          pix_idx = 0;
    int          extra_bad = 0;
    bit          extra_en = 1'b0;
    int          sd_a;
    int          sd_idx;
    bit          sd_abort;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pixel FIFO: one pixel per strobe, presented before the DUT samples it.
    always @(negedge clk) begin
        if (pix_rd_en === 1'b1) begin
            pix_data = (pix_idx < NPIX) ? pix_mem[pix_idx] : 24'h0;
            pix_idx++;
        end
    end

    // SD sector writer: 512 byte requests per sector, spaced 3..5 cycles, then an end pulse.
    always begin
        @(negedge clk);
        if (sd_sec_write === 1'b1) begin
            sd_a     = int'(sd_sec_write_addr);
            sd_abort = 1'b0;
            addr_log.push_back(sd_a);
            for (int i = 0; i < 512 && !sd_abort; i++) begin
                sd_sec_write_data_req = 1'b1;
                @(negedge clk);
                sd_sec_write_data_req = 1'b0;
                if (sd_sec_write !== 1'b1) begin
                    sd_abort = 1'b1;
                end else begin
                    sd_idx = (sd_a - SS) * 512 + i;
                    if (sd_idx >= 0 && sd_idx < NBYTES) cap[sd_idx] = sd_sec_write_data;
                end
                repeat (2 + $urandom_range(0, 2)) @(negedge clk);
            end
            if (extra_en && !sd_abort) begin
                sd_sec_write_data_req = 1'b1;
                @(negedge clk);
                sd_sec_write_data_req = 1'b0;
                if (sd_sec_write_data !== 8'h00) extra_bad++;
                repeat (2) @(negedge clk);
            end
            if (!sd_abort) begin
                sd_sec_write_end = 1'b1;
                @(negedge clk);
                sd_sec_write_end = 1'b0;
            end
        end
    end

    task automatic put_le(input int off, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_b[off + i] = v[8*i +: 8];
    endtask

    task automatic build_exp(input bit fixed_pat);
        int off;
        logic [31:0] hfield;
        for (int i = 0; i < NPIX; i++)
            pix_mem[i] = fixed_pat ? 24'(32'h112233 + 32'h333333 * 32'(i)) : 24'($urandom);
        for (int i = 0; i < NBYTES; i++) exp_b[i] = 8'h00;
`ifdef BMP_TOP_DOWN_EN
        hfield = -32'(H);
`else
        hfield = 32'(H);
`endif
        exp_b[0] = "B";
        exp_b[1] = "M";
        put_le(2, FLEN, 4);
        put_le(10, 54, 4);
        put_le(14, 40, 4);
        put_le(18, W, 4);
        put_le(22, hfield, 4);
        put_le(26, 1, 2);
        put_le(28, 24, 2);
        put_le(34, IMGSZ, 4);
        put_le(38, 2835, 4);
        put_le(42, 2835, 4);
        off = 54;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_b[off]     = pix_mem[r*W + c][7:0];
                exp_b[off + 1] = pix_mem[r*W + c][15:8];
                exp_b[off + 2] = pix_mem[r*W + c][23:16];
                off += 3;
            end
            off += PAD;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_ready"}, 32'(ready), 32'd1);
        chk({pfx, "_state_code"}, 32'(state_code), 32'd0);
        chk({pfx, "_read_req"}, 32'(read_req), 32'd0);
        chk({pfx, "_pix_rd_en"}, 32'(pix_rd_en), 32'd0);
        chk({pfx, "_sec_write"}, 32'(sd_sec_write), 32'd0);
        chk({pfx, "_addr"}, sd_sec_write_addr, 32'(SS));
        chk({pfx, "_data"}, 32'(sd_sec_write_data), 32'd0);
    endtask

    task automatic run_file(input string tag, input int ack_dly, input bit fixed_pat,
                            input bit extra, input bit abort3);
        int hold;
        int cyc;
        logic [7:0] row_lit [12];
        row_lit = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44, 8'h99, 8'h88, 8'h77, 8'h00, 8'h00, 8'h00};
        build_exp(fixed_pat);
        for (int i = 0; i < NBYTES; i++) cap[i] = 8'hEE;
        addr_log.delete();
        pix_idx   = 0;
        extra_bad = 0;
        extra_en  = extra;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold = 0;
        for (int i = 0; i < ack_dly; i++) begin
            if (read_req === 1'b1 && sd_sec_write === 1'b0) hold++;
            @(negedge clk);
        end
        read_req_ack = 1'b1;
        @(negedge clk);
        read_req_ack = 1'b0;
        chk({tag, "_req_hold"}, 32'(hold), 32'(ack_dly));
        chk({tag, "_req_drop"}, 32'(read_req), 32'd0);
        if (abort3) begin
            for (cyc = 0; cyc < 20000 && addr_log.size() < 3; cyc++) @(negedge clk);
            chk({tag, "_reach_sec3"}, 32'(addr_log.size() >= 3), 32'd1);
            repeat (40) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_reset_values({tag, "_abort"});
            repeat (10) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(negedge clk);
            return;
        end
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 20000 && state_code !== 2'd3; cyc++) @(negedge clk);
        chk({tag, "_done_code"}, 32'(state_code), 32'd3);
        chk({tag, "_ready_in_end"}, 32'(ready), 32'd0);
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_code_sticky"}, 32'(state_code), 32'd3);
        chk({tag, "_nsec"}, 32'(addr_log.size()), 32'(NSEC));
        for (int i = 0; i < addr_log.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(SS + i));
        for (int i = 0; i < NBYTES; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_b[i]));
        chk({tag, "_pix_reads"}, 32'(pix_idx), 32'(NPIX));
        if (fixed_pat)
            for (int k = 0; k < 12; k++)
                chk($sformatf("%s_row0_%0d", tag, k), 32'(cap[54 + k]), 32'(row_lit[k]));
        if (extra) chk({tag, "_extra_req_zero"}, 32'(extra_bad), 32'd0);
    endtask

    initial begin
        rst_n                 = 1'b0;
        sd_init_done          = 1'b1;
        start                 = 1'b0;
        read_req_ack          = 1'b0;
        pix_data              = 24'h0;
        sd_sec_write_data_req = 1'b0;
        sd_sec_write_end      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_code", 32'(state_code), 32'd1);
        chk("idle_ready", 32'(ready), 32'd1);

        sd_init_done = 1'b0;
        @(negedge clk);
        chk("noinit_code", 32'(state_code), 32'd0);
        chk("noinit_ready", 32'(ready), 32'd1);
        sd_init_done = 1'b1;
        repeat (2) @(negedge clk);
        chk("reinit_code", 32'(state_code), 32'd1);

        run_file("pat", 50, 1'b1, 1'b0, 1'b0);
        run_file("rnd", 3, 1'b0, 1'b1, 1'b0);
        run_file("abort", 5, 1'b0, 1'b0, 1'b1);
        chk("post_abort_code", 32'(state_code), 32'd1);
        run_file("restart", 7, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
